// File: rtl/pe_pkg.sv
// Shared constants, data type and rescale/saturate helper for the PE datapath.
package pe_pkg;

  localparam int unsigned PE_WIDTH  = 16;
  localparam int unsigned PE_FRAC   = 12;
  localparam int unsigned PE_LANES  = 3;
  localparam int unsigned RESCALE_W = 64;

  typedef logic signed [PE_WIDTH-1:0] pe_data_t;

  typedef struct packed {
    logic                        ovf;
    logic signed [RESCALE_W-1:0] val;
  } pe_rescale_t;

  // Arithmetic shift right by frac (floor), optionally clamped to a signed width-bit range.
  function automatic pe_rescale_t pe_rescale(input logic signed [RESCALE_W-1:0] x,
                                             input int unsigned frac,
                                             input int unsigned width,
                                             input logic sat);
    pe_rescale_t                 res;
    logic signed [RESCALE_W-1:0] r;
    logic signed [RESCALE_W-1:0] hi;
    logic signed [RESCALE_W-1:0] lo;
    r  = x >>> frac;
    hi = (RESCALE_W'(1) <<< (width - 1)) - RESCALE_W'(1);
    lo = ~hi;
    res.ovf = 1'b0;
    res.val = r;
    if (sat) begin
      if (r > hi) begin
        res.val = hi;
        res.ovf = 1'b1;
      end else if (r < lo) begin
        res.val = lo;
        res.ovf = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pe_fx_mult.sv
// Registered signed WIDTH x WIDTH multiplier producing the full 2*WIDTH-bit product.
module pe_fx_mult #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  output logic signed [2*WIDTH-1:0]   p
);

  localparam int unsigned PW = 2 * WIDTH;

  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
    end else if (en) begin
      p <= PW'(a) * PW'(b);
    end
  end

endmodule

// File: rtl/pe_dot_acc.sv
// Pipelined signed fixed-point dot-product accumulator: multiply, lane sum, window accumulate.
// Define PE_DOT_SATURATE_EN to clamp out-of-range results and flag them on out_ovf.
module pe_dot_acc
  import pe_pkg::*;
#(
  parameter int unsigned WIDTH = PE_WIDTH,
  parameter int unsigned FRAC  = PE_FRAC,
  parameter int unsigned LANES = PE_LANES,
  parameter int unsigned ACC_W = 2 * WIDTH + 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_ovf
);

  localparam int unsigned PW = 2 * WIDTH;

`ifdef PE_DOT_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic                    adv;
  logic signed [PW-1:0]    prod [LANES];
  logic                    s1_valid;
  logic                    s1_last;
  logic                    s2_valid;
  logic                    s2_last;
  logic signed [ACC_W-1:0] s2_sum;
  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next_c;
  logic                    first;
  pe_rescale_t             res_c;
  logic                    rescale_unused;

  // Whole pipeline stalls only while a result is pending and not taken.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: one registered multiplier per lane.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_fx_mult #(.WIDTH(WIDTH)) u_mult (
      .clk (clk),
      .rst (rst),
      .en  (adv),
      .a   (in_a[i*WIDTH +: WIDTH]),
      .b   (in_b[i*WIDTH +: WIDTH]),
      .p   (prod[i])
    );
  end

  // Sign-extended sum of all lane products.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_c = sum_c + ACC_W'(prod[i]);
    end
  end

  assign acc_next_c     = first ? s2_sum : acc + s2_sum;
  assign res_c          = pe_rescale(RESCALE_W'(acc_next_c), FRAC, WIDTH, SAT_EN);
  assign rescale_unused = ^res_c.val[RESCALE_W-1:WIDTH];

  // S1/S2 control and S2 sum registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_sum   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_last  <= in_valid && in_last;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_sum   <= sum_c;
    end
  end

  // S3: window accumulator; a closing beat rearms first so windows never mix.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= 1'b0;
      if (s2_valid) begin
        if (s2_last) begin
          acc       <= '0;
          first     <= 1'b1;
          out_valid <= 1'b1;
          out_data  <= res_c.val[WIDTH-1:0];
        end else begin
          acc   <= acc_next_c;
          first <= 1'b0;
        end
      end
    end
  end

`ifdef PE_DOT_SATURATE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ovf <= 1'b0;
    end else if (adv && s2_valid && s2_last) begin
      out_ovf <= res_c.ovf;
    end
  end
`else
  logic ovf_unused;
  assign ovf_unused = res_c.ovf;
  assign out_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_pe_dot_acc.sv
// Directed self-checking bench for pe_dot_acc at default parameters (1.0 = 0x1000).
module tb_pe_dot_acc;

  localparam int unsigned W = 16;
  localparam int unsigned L = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [L*W-1:0] in_a;
  logic [L*W-1:0] in_b;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_ovf;

  int checks = 0;
  int errors = 0;

  pe_dot_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat at a negedge and return at the negedge after it is accepted.
  task automatic drive(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                       input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2,
                       input logic last);
    int n;
    in_a     = {a2, a1, a0};
    in_b     = {b2, b1, b0};
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait (bounded) for a result, check it, then step past its consuming edge.
  task automatic expect_result(input string tag, input logic [15:0] exp_d, input logic exp_o);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(exp_d));
    check({tag, "_ovf"}, 32'(out_ovf), 32'(exp_o));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single beat with 3-cycle latency: 1*1 + 2*1 + 0.5*1 = 3.5
    drive(16'h1000, 16'h2000, 16'h0800, 16'h1000, 16'h1000, 16'h1000, 1'b1);
    check("t1_lat1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t1_lat2", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'h3800);
    check("t1_ovf", 32'(out_ovf), 32'd0);
    @(negedge clk);
    check("t1_drop", 32'(out_valid), 32'd0);

    // Back-to-back windows: 2 beats of 3*0.5 = 3.0, then -1.0
    drive(16'h0800, 16'h0800, 16'h0800, 16'h1000, 16'h1000, 16'h1000, 1'b0);
    drive(16'h0800, 16'h0800, 16'h0800, 16'h1000, 16'h1000, 16'h1000, 1'b1);
    drive(16'hF000, 16'h0000, 16'h0000, 16'h1000, 16'h0000, 16'h0000, 1'b1);
    expect_result("t2_w1", 16'h3000, 1'b0);
    check("t2_w2_back_to_back", 32'(out_valid), 32'd1);
    expect_result("t2_w2", 16'hF000, 1'b0);
    check("t2_idle", 32'(out_valid), 32'd0);

    // Truncation toward -inf
    drive(16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 1'b1);
    expect_result("t3_pos", 16'h0000, 1'b0);
    drive(16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 1'b1);
    expect_result("t3_neg", 16'hFFFF, 1'b0);

    // Overflow: 4 beats of 3*1.0 = 12.0
    for (int i = 0; i < 4; i++) begin
      drive(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, (i == 3));
    end
`ifdef PE_DOT_SATURATE_EN
    expect_result("t4_ovf", 16'h7FFF, 1'b1);
`else
    expect_result("t4_ovf", 16'hC000, 1'b0);
`endif

    // Backpressure: case-1 result stalls while a 3-beat window (4.5) streams in
    out_ready = 1'b0;
    drive(16'h1000, 16'h2000, 16'h0800, 16'h1000, 16'h1000, 16'h1000, 1'b1);
    drive(16'h0800, 16'h0800, 16'h0800, 16'h1000, 16'h1000, 16'h1000, 1'b0);
    drive(16'h0800, 16'h0800, 16'h0800, 16'h1000, 16'h1000, 16'h1000, 1'b0);
    in_a     = {16'h0800, 16'h0800, 16'h0800};
    in_b     = {16'h1000, 16'h1000, 16'h1000};
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_hold_valid", 32'(out_valid), 32'd1);
      check("t5_hold_data", 32'(out_data), 32'h3800);
      check("t5_hold_ovf", 32'(out_ovf), 32'd0);
      check("t5_hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    drive(16'h0800, 16'h0800, 16'h0800, 16'h1000, 16'h1000, 16'h1000, 1'b1);
    check("t5_release_drop", 32'(out_valid), 32'd0);
    expect_result("t5_next", 16'h4800, 1'b0);
    check("t5_no_dup", 32'(out_valid), 32'd0);

    // Reset mid-window discards the partial accumulation
    drive(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 1'b0);
    drive(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd1);
    drive(16'h1000, 16'h2000, 16'h0800, 16'h1000, 16'h1000, 16'h1000, 1'b1);
    expect_result("t6_after_rst", 16'h3800, 1'b0);
    repeat (3) @(negedge clk);
    check("t6_quiet", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
